// File: rtl/paddle_pkg.sv
// Shared types and helpers for the mouse-to-paddle emulator.
//   DELTA_W  : width of the signed mouse deltas
//   src_t    : per-channel source selection (analog stick or mouse)
//   sat_add  : add two values and clip the result to [lo, hi]
package paddle_pkg;

   localparam int DELTA_W = 9;

   typedef enum logic {SRC_ANALOG, SRC_MOUSE} src_t;

   function automatic int sat_add(input int a, input int b, input int lo, input int hi);
      int s;
      s = a + b;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/paddle_axis.sv
// One paddle axis: clamp a mouse delta, scale it, optionally invert it, and
// add it to a saturating position accumulator.
//   clk_sys, reset : clock, synchronous active-high reset
//   step_i         : accumulate delta_i this cycle
//   clr_i          : clear the accumulator (wins over step_i)
//   delta_i        : signed mouse delta
//   sens_i         : left shift applied after clamping (0..3)
//   inv_i          : negate the scaled step
//   acc_d_o        : next accumulator value (so the parent can register it
//                    into the paddle output in the same cycle)
module paddle_axis
   import paddle_pkg::*;
#(
   parameter int W        = 8,
   parameter int STEP_MAX = 10
) (
   input  logic                      clk_sys,
   input  logic                      reset,
   input  logic                      step_i,
   input  logic                      clr_i,
   input  logic signed [DELTA_W-1:0] delta_i,
   input  logic        [1:0]         sens_i,
   input  logic                      inv_i,
   output logic signed [W-1:0]       acc_d_o
);

   // Wide enough for STEP_MAX << 3 plus the sign without overflow.
   localparam int IW = W + 6;
   localparam logic signed [IW-1:0] SMAX = IW'(STEP_MAX);

   logic signed [IW-1:0] dext, clamped, scaled, step;
   logic signed [W-1:0]  acc_q;

   always_comb begin
      dext = IW'(delta_i);
      if (dext > SMAX)       clamped = SMAX;
      else if (dext < -SMAX) clamped = -SMAX;
      else                   clamped = dext;
      scaled = clamped <<< sens_i;
      step   = inv_i ? -scaled : scaled;
   end

   always_comb begin
      acc_d_o = acc_q;
      if (clr_i)
         acc_d_o = '0;
      else if (step_i)
         acc_d_o = W'(sat_add(int'(acc_q), int'(step), -(2**(W-1)), 2**(W-1)-1));
   end

   always_ff @(posedge clk_sys) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d_o;
   end

endmodule

// File: rtl/mouse_paddle_emu.sv
// Multi-channel mouse-to-paddle emulator. Each channel turns toggle-strobed
// relative mouse deltas into absolute paddle positions, and falls back to the
// analog stick when the stick is moved or the mouse goes quiet.
//   clk_sys, reset    : clock, synchronous active-high reset
//   m_stb             : per-channel event toggle (any change = one event)
//   m_dx, m_dy        : signed 9-bit deltas per channel
//   m_btn             : 3 mouse buttons per channel
//   joya              : analog stick per channel, [7:0]=X, [15:8]=Y
//   sens              : global step left shift
//   inv               : per-channel invert {Y,X}
//   recentre          : per-channel accumulator clear
//   pad_x, pad_y      : registered paddle positions
//   pad_btn           : registered buttons (0 while analog-driven)
//   src_mouse         : 1 while the channel is mouse-driven
module mouse_paddle_emu
   import paddle_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int W        = 8,
   parameter int STEP_MAX = 10,
   parameter int DEADZONE = 4,
   parameter int IDLE_CYC = 0
) (
   input  logic                        clk_sys,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           m_stb,
   input  logic [NUM_CH*DELTA_W-1:0]   m_dx,
   input  logic [NUM_CH*DELTA_W-1:0]   m_dy,
   input  logic [NUM_CH*3-1:0]         m_btn,
   input  logic [NUM_CH*16-1:0]        joya,
   input  logic [1:0]                  sens,
   input  logic [NUM_CH*2-1:0]         inv,
   input  logic [NUM_CH-1:0]           recentre,
   output logic [NUM_CH*W-1:0]         pad_x,
   output logic [NUM_CH*W-1:0]         pad_y,
   output logic [NUM_CH*3-1:0]         pad_btn,
   output logic [NUM_CH-1:0]           src_mouse
);

   localparam int CNT_W = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

   // Tracking the strobe during reset too means a level held across reset
   // release is not seen as an event.
   logic [NUM_CH-1:0] stb_q;
   always_ff @(posedge clk_sys) stb_q <= m_stb;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      src_t              src_q, src_d;
      logic [CNT_W-1:0]  idle_q, idle_d;
      logic              evt, ana_act, idle_exp, take, clr;
      logic signed [7:0] jx, jy;
      logic signed [W-1:0] accx_d, accy_d;
      logic [W-1:0]      padx_q, pady_q;
      logic [2:0]        btn_q;

      assign jx       = joya[c*16 +: 8];
      assign jy       = joya[c*16+8 +: 8];
      assign evt      = m_stb[c] ^ stb_q[c];
      assign ana_act  = (int'(jx) > DEADZONE) || (int'(jx) < -DEADZONE) ||
                        (int'(jy) > DEADZONE) || (int'(jy) < -DEADZONE);
      // >= rather than == so a counter that overshoots still times out.
      assign idle_exp = (IDLE_CYC != 0) && (int'(idle_q) >= IDLE_CYC - 1);

      always_comb begin
         src_d = src_q;
         take  = 1'b0;
         clr   = 1'b0;
         unique case (src_q)
            SRC_ANALOG: begin
               // Stick activity or a same-cycle recentre drops the event.
               if (evt && !ana_act && !recentre[c]) begin
                  src_d = SRC_MOUSE;
                  take  = 1'b1;
               end
            end
            SRC_MOUSE: begin
               if (ana_act) begin
                  src_d = SRC_ANALOG;
                  clr   = 1'b1;
               end else begin
                  if (recentre[c]) clr  = 1'b1;
                  else if (evt)    take = 1'b1;
                  if (!evt && idle_exp) begin
                     src_d = SRC_ANALOG;
                     clr   = 1'b1;
                  end
               end
            end
         endcase

         idle_d = idle_q;
         if (src_d == SRC_ANALOG || take) idle_d = '0;
         else if (idle_q != '1)           idle_d = idle_q + 1'b1;
      end

      paddle_axis #(.W(W), .STEP_MAX(STEP_MAX)) u_ax_x (
         .clk_sys (clk_sys),
         .reset   (reset),
         .step_i  (take),
         .clr_i   (clr),
         .delta_i (m_dx[c*DELTA_W +: DELTA_W]),
         .sens_i  (sens),
         .inv_i   (inv[c*2]),
         .acc_d_o (accx_d)
      );

      paddle_axis #(.W(W), .STEP_MAX(STEP_MAX)) u_ax_y (
         .clk_sys (clk_sys),
         .reset   (reset),
         .step_i  (take),
         .clr_i   (clr),
         .delta_i (m_dy[c*DELTA_W +: DELTA_W]),
         .sens_i  (sens),
         .inv_i   (inv[c*2+1]),
         .acc_d_o (accy_d)
      );

      always_ff @(posedge clk_sys) begin
         if (reset) begin
            src_q  <= SRC_ANALOG;
            idle_q <= '0;
            padx_q <= '0;
            pady_q <= '0;
            btn_q  <= '0;
         end else begin
            src_q  <= src_d;
            idle_q <= idle_d;
            if (src_d == SRC_MOUSE) begin
               padx_q <= accx_d;
               pady_q <= accy_d;
               if (take) btn_q <= m_btn[c*3 +: 3];
            end else begin
               // Stick values pass straight through, deadzone included.
               padx_q <= W'(jx);
               pady_q <= W'(jy);
               btn_q  <= '0;
            end
         end
      end

      assign pad_x[c*W +: W]   = padx_q;
      assign pad_y[c*W +: W]   = pady_q;
      assign pad_btn[c*3 +: 3] = btn_q;
      assign src_mouse[c]      = (src_q == SRC_MOUSE);
   end

endmodule
